// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: request/response
// structs, FSM/owner/kind enums and the request classifier.
package mem_arb_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } memory_io_rsp;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} arb_state_e;
  typedef enum logic {OWN_INST, OWN_DATA} arb_owner_e;
  typedef enum logic [1:0] {TXN_NULL, TXN_READ, TXN_WRITE} txn_kind_e;

  // Any write strobe makes it a write, even if read strobes are also set.
  function automatic txn_kind_e classify(input memory_io_req r);
    if (r.do_write != '0) return TXN_WRITE;
    if (r.do_read != '0) return TXN_READ;
    return TXN_NULL;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Data-over-instruction priority with a starvation counter that forces an
// instruction grant after STARVE_LIMIT consecutive data grants.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inst_pend_i,
  input  logic data_pend_i,
  input  logic idle_stb_i,
  output logic grant_data_o
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q;
  logic [SW-1:0] starve_cnt_d;

  assign grant_data_o = data_pend_i && !(inst_pend_i && (starve_cnt_q == LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle_stb_i) begin
      if (grant_data_o && inst_pend_i) starve_cnt_d = starve_cnt_q + SW'(1);
      else                             starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters: one transaction in
// flight, registered mem_req, combinational response routing to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req inst_req,
  output logic         inst_req_ack,
  output memory_io_rsp inst_rsp,
  input  memory_io_req data_req,
  output logic         data_req_ack,
  output memory_io_rsp data_rsp,
  output memory_io_req mem_req,
  input  logic         mem_req_ack,
  input  memory_io_rsp mem_rsp,
  output logic         busy,
  output logic         timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e    state_q;
  arb_owner_e    owner_q;
  txn_kind_e     kind_q;
  memory_io_req  mem_req_q;
  logic          inst_ack_q;
  logic          data_ack_q;
  logic          timeout_err_q;
  logic [CW-1:0] tmo_cnt_q;

  logic          inst_pend;
  logic          data_pend;
  logic          idle_stb;
  logic          grant_data;
  memory_io_req  win_req;
  txn_kind_e     win_kind;
  logic          rsp_gate;
  logic          done;
  logic          tmo_hit;
  memory_io_rsp  rsp_out;

  // The ack pulse lands while the requester still holds valid; mask it so a
  // null request is not granted twice.
  assign inst_pend = inst_req.valid && !inst_ack_q;
  assign data_pend = data_req.valid && !data_ack_q;
  assign idle_stb  = (state_q == IDLE) && (inst_pend || data_pend);

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk          (clk),
    .rst_n        (reset),
    .inst_pend_i  (inst_pend),
    .data_pend_i  (data_pend),
    .idle_stb_i   (idle_stb),
    .grant_data_o (grant_data)
  );

  assign win_req  = grant_data ? data_req : inst_req;
  assign win_kind = classify(win_req);
  assign rsp_gate = (state_q == WAIT_RSP) || ((state_q == ISSUE) && mem_req_ack);

  always_comb begin
    done = 1'b0;
    case (state_q)
      ISSUE:    done = mem_req_ack && ((kind_q == TXN_WRITE) || mem_rsp.valid);
      WAIT_RSP: done = mem_rsp.valid;
      default:  done = 1'b0;
    endcase
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) &&
                   (tmo_cnt_q == TO_LAST) && !done;

  always_comb begin
    rsp_out  = '0;
    inst_rsp = '0;
    data_rsp = '0;
    if (rsp_gate && mem_rsp.valid) rsp_out = mem_rsp;
    else if (tmo_hit)              rsp_out.valid = 1'b1;
    if (owner_q == OWN_INST) inst_rsp = rsp_out;
    else                     data_rsp = rsp_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_INST;
      kind_q        <= TXN_NULL;
      mem_req_q     <= '0;
      inst_ack_q    <= 1'b0;
      data_ack_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      inst_ack_q <= 1'b0;
      data_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idle_stb) begin
            inst_ack_q <= !grant_data;
            data_ack_q <= grant_data;
            owner_q    <= grant_data ? OWN_DATA : OWN_INST;
            kind_q     <= win_kind;
            if (win_kind != TXN_NULL) begin
              mem_req_q       <= win_req;
              mem_req_q.valid <= 1'b1;
              tmo_cnt_q       <= '0;
              state_q         <= ISSUE;
            end
          end
        end
        ISSUE, WAIT_RSP: begin
          tmo_cnt_q <= tmo_cnt_q + CW'(1);
          if (done) begin
            mem_req_q.valid <= 1'b0;
            state_q         <= IDLE;
          end else if (tmo_hit) begin
            mem_req_q.valid <= 1'b0;
            timeout_err_q   <= 1'b1;
            state_q         <= IDLE;
          end else if ((state_q == ISSUE) && mem_req_ack) begin
            mem_req_q.valid <= 1'b0;
            state_q         <= WAIT_RSP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign inst_req_ack = inst_ack_q;
  assign data_req_ack = data_ack_q;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with STARVE_LIMIT=2, TIMEOUT_CYCLES=4.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  memory_io_req inst_req, data_req, mem_req;
  memory_io_rsp inst_rsp, data_rsp, mem_rsp;
  logic         inst_req_ack, data_req_ack, mem_req_ack, busy, timeout_err;
  int           checks = 0;
  int           errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(2), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_req_ack(inst_req_ack), .inst_rsp(inst_rsp),
    .data_req(data_req), .data_req_ack(data_req_ack), .data_rsp(data_rsp),
    .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_rsp(mem_rsp),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; inst_req = '0; data_req = '0; mem_req_ack = 1'b0;
    mem_rsp = '{valid: 1'b1, data: 32'hDEAD0001};
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mem_req !== '0) begin errors++; $display("FAIL reset_mem_req: got %h want 0", mem_req); end
    cyc(); mid();
    checks++; if ({inst_req_ack, data_req_ack, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {inst_req_ack, data_req_ack, timeout_err}); end
    checks++; if (inst_rsp !== '0 || data_rsp !== '0) begin errors++; $display("FAIL reset_rsp: got %h/%h want 0/0", inst_rsp, data_rsp); end
    cyc(); reset = 1'b1; mem_rsp = '0;
  endtask

  task automatic test_fetch_read();
    cyc(); inst_req = '{valid: 1'b1, addr: 32'h100, data: 32'h0, do_read: 4'hF, do_write: 4'h0};
    mid();
    checks++; if (mem_req.valid !== 1'b0 || inst_req_ack !== 1'b0) begin errors++; $display("FAIL fetch_n: got vld=%b ack=%b want 0 0", mem_req.valid, inst_req_ack); end
    cyc(); mem_req_ack = 1'b1; mid();
    checks++; if (inst_req_ack !== 1'b1 || data_req_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack: got i=%b d=%b want 1 0", inst_req_ack, data_req_ack); end
    checks++; if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h100 || mem_req.do_read !== 4'hF) begin errors++; $display("FAIL fetch_mem_req: got %h", mem_req); end
    cyc(); mem_req_ack = 1'b0; inst_req = '0; mid();
    checks++; if (inst_rsp.valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_wait: got rsp=%b busy=%b want 0 1", inst_rsp.valid, busy); end
    cyc(); mem_rsp = '{valid: 1'b1, data: 32'h00500093}; mid();
    checks++; if (inst_rsp !== '{valid: 1'b1, data: 32'h00500093}) begin errors++; $display("FAIL fetch_rsp: got %h want 100500093", inst_rsp); end
    checks++; if (data_rsp.valid !== 1'b0) begin errors++; $display("FAIL fetch_data_rsp: got %b want 0", data_rsp.valid); end
    cyc(); mem_rsp = '0; mid();
    checks++; if (busy !== 1'b0 || inst_rsp.valid !== 1'b0) begin errors++; $display("FAIL fetch_done: got busy=%b rsp=%b want 0 0", busy, inst_rsp.valid); end
  endtask

  task automatic test_data_write();
    memory_io_req exp;
    exp = '{valid: 1'b1, addr: 32'h2000, data: 32'hCAFEF00D, do_read: 4'h0, do_write: 4'hF};
    cyc(); data_req = exp; mid();
    cyc(); mem_req_ack = 1'b1; mid();
    checks++; if (mem_req !== exp) begin errors++; $display("FAIL write_mem_req: got %h want %h", mem_req, exp); end
    checks++; if (data_req_ack !== 1'b1 || inst_req_ack !== 1'b0) begin errors++; $display("FAIL write_ack: got d=%b i=%b want 1 0", data_req_ack, inst_req_ack); end
    checks++; if (inst_rsp.valid !== 1'b0 || data_rsp.valid !== 1'b0) begin errors++; $display("FAIL write_rsp: got i=%b d=%b want 0 0", inst_rsp.valid, data_rsp.valid); end
    cyc(); data_req = '0; mem_req_ack = 1'b0; mid();
    checks++; if (busy !== 1'b0 || mem_req.valid !== 1'b0 || data_req_ack !== 1'b0) begin errors++; $display("FAIL write_idle: got busy=%b vld=%b ack=%b want 0 0 0", busy, mem_req.valid, data_req_ack); end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_seq [6];
    logic [1:0] exp;
    // {inst_ack, data_ack}: D, D, I, D, D, I
    exp_seq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    cyc();
    inst_req = '{valid: 1'b1, addr: 32'h10, data: 32'h1, do_read: 4'h0, do_write: 4'h1};
    data_req = '{valid: 1'b1, addr: 32'h20, data: 32'h2, do_read: 4'h0, do_write: 4'h1};
    mem_req_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      mid();
      exp = (c % 2 == 1) ? exp_seq[c / 2] : 2'b00;
      checks++;
      if ({inst_req_ack, data_req_ack} !== exp) begin
        errors++; $display("FAIL starve_cycle%0d: got %b want %b", c, {inst_req_ack, data_req_ack}, exp);
      end
    end
    cyc(); inst_req = '0; data_req = '0; mem_req_ack = 1'b0; mid();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_null_request();
    cyc(); data_req = '{valid: 1'b1, addr: 32'h40, data: 32'h0, do_read: 4'h0, do_write: 4'h0}; mid();
    cyc(); mid();
    checks++; if (data_req_ack !== 1'b1 || mem_req.valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL null_ack: got ack=%b vld=%b busy=%b want 1 0 0", data_req_ack, mem_req.valid, busy); end
    cyc(); data_req = '0; mid();
    checks++; if (data_req_ack !== 1'b0 || mem_req.valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL null_after: got ack=%b vld=%b busy=%b want 0 0 0", data_req_ack, mem_req.valid, busy); end
  endtask

  task automatic test_timeout();
    cyc();
    inst_req = '{valid: 1'b1, addr: 32'h300, data: 32'h0, do_read: 4'hF, do_write: 4'h0};
    mem_rsp = '{valid: 1'b0, data: 32'hDEADBEEF};
    mid();
    cyc(); mem_req_ack = 1'b1; mid();
    checks++; if (inst_req_ack !== 1'b1) begin errors++; $display("FAIL tmo_ack: got %b want 1", inst_req_ack); end
    cyc(); inst_req = '0; mem_req_ack = 1'b0; mid();
    checks++; if (inst_rsp !== '0) begin errors++; $display("FAIL tmo_c2: got %h want 0", inst_rsp); end
    cyc(); mid();
    checks++; if (inst_rsp.valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_c3: got rsp=%b err=%b want 0 0", inst_rsp.valid, timeout_err); end
    cyc(); mid();
    checks++; if (inst_rsp !== '{valid: 1'b1, data: 32'h0}) begin errors++; $display("FAIL tmo_rsp: got %h want 100000000", inst_rsp); end
    checks++; if (data_rsp.valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_c4: got drsp=%b busy=%b want 0 1", data_rsp.valid, busy); end
    cyc(); mid();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0 || mem_req.valid !== 1'b0 || inst_rsp.valid !== 1'b0) begin errors++; $display("FAIL tmo_after: got err=%b busy=%b vld=%b rsp=%b want 1 0 0 0", timeout_err, busy, mem_req.valid, inst_rsp.valid); end
    cyc(); cyc(); mid();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    mem_rsp = '0;
  endtask

  task automatic test_reset_mid_wait();
    cyc(); data_req = '{valid: 1'b1, addr: 32'h400, data: 32'h0, do_read: 4'h3, do_write: 4'h0}; mid();
    cyc(); mem_req_ack = 1'b1; mid();
    checks++; if (data_req_ack !== 1'b1) begin errors++; $display("FAIL rstw_ack: got %b want 1", data_req_ack); end
    cyc(); data_req = '0; mem_req_ack = 1'b0; mid();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_wait: got busy=%b want 1", busy); end
    reset = 1'b0; #1;
    checks++; if (busy !== 1'b0 || mem_req !== '0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rstw_async: got busy=%b req=%h err=%b want 0 0 0", busy, mem_req, timeout_err); end
    mem_rsp = '{valid: 1'b1, data: 32'h12345678}; #1;
    checks++; if (data_rsp !== '0 || inst_rsp !== '0) begin errors++; $display("FAIL rstw_late_in_reset: got %h/%h want 0/0", data_rsp, inst_rsp); end
    cyc(); reset = 1'b1; mid();
    checks++; if (data_rsp !== '0 || inst_rsp !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstw_late_after: got %h/%h busy=%b want 0/0 0", data_rsp, inst_rsp, busy); end
    cyc(); mem_rsp = '0; mid();
    checks++; if ({inst_req_ack, data_req_ack, busy} !== 3'b000) begin errors++; $display("FAIL rstw_quiet: got %b want 000", {inst_req_ack, data_req_ack, busy}); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_starvation();
    test_null_request();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified memory port between the core's instruction-fetch requester and its data requester. It accepts `memory_io_req` transactions from both, and grants one at a time with data-over-instruction priority and a starvation guard. It issues the granted request downstream with a valid/ack handshake and routes the returned `memory_io_rsp` back to the owner. It sits between `core32` and a single-ported memory.

## Interface
- `STARVE_LIMIT`, default 2: consecutive data grants allowed while an instruction request is pending.
- `TIMEOUT_CYCLES`, default 64: cycles allowed in ISSUE plus WAIT_RSP before abort. A value of 0 disables the timeout.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `inst_req` in `memory_io_req`: fetch request.
- `inst_req_ack` out 1: one-cycle grant pulse to the fetch requester.
- `inst_rsp` out `memory_io_rsp`: fetch response.
- `data_req` in `memory_io_req`: load/store request.
- `data_req_ack` out 1: one-cycle grant pulse to the data requester.
- `data_rsp` out `memory_io_rsp`: load response.
- `mem_req` out `memory_io_req`: downstream request, registered.
- `mem_req_ack` in 1: downstream accepts `mem_req` in the current cycle.
- `mem_rsp` in `memory_io_rsp`: downstream read response.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: sticky abort flag.

## Operation
- **Requester contract:** a request is pending when `.valid` is 1. The requester holds all fields stable until it sees its ack.
- **Classification:**
  - Write: `do_write != 0`.
  - Read: `do_read != 0` and `do_write == 0`.
  - Null: both fields zero.
- **Arbitration (IDLE only):**
  - Data wins by default.
  - If both are pending and `starve_cnt == STARVE_LIMIT`, instruction wins.
  - `starve_cnt` increments on a data grant while instruction is pending.
  - `starve_cnt` clears on an instruction grant, or on a data grant while instruction is idle.
- **States:**
  - **IDLE:** if any request is pending, latch the winner into `mem_req`, record `owner`, pulse the ack next cycle.
    - Null request: ack only, stay in IDLE.
    - Otherwise go to ISSUE.
  - **ISSUE:** `mem_req.valid` = 1.
    - On `mem_req_ack`, a write goes to IDLE.
    - On `mem_req_ack`, a read goes to WAIT_RSP, or completes directly to IDLE if `mem_rsp.valid` is also 1 that cycle.
  - **WAIT_RSP:** when `mem_rsp.valid` is 1, go to IDLE.
- **Response routing:** combinational. The owner's rsp equals `mem_rsp` with `.valid` gated by (state is WAIT_RSP, or ISSUE with `mem_req_ack`) and owner match. The non-owner's rsp `.valid` is 0.
- **Timeout:**
  - The counter runs in ISSUE/WAIT_RSP and clears on entry to ISSUE.
  - When it reaches `TIMEOUT_CYCLES`, the owner's rsp `.valid` = 1 with `.data` = 0 for one cycle.
  - `mem_req.valid` drops, state goes to IDLE, and `timeout_err` is set until reset.
- **Ignored inputs:** `mem_rsp.valid` outside the gating conditions is ignored.
- **Reset (any time, including mid-transaction):** state IDLE, owner dropped, all counters 0. Requesters must re-issue.

## Timing
- Reset values: all output struct fields 0, both acks 0, `busy` 0, `timeout_err` 0.
- Grant latency:
  - Request valid in IDLE at cycle N.
  - `mem_req.valid` and the ack are both high in N+1.
- Write latency: completes in the cycle `mem_req_ack` is sampled. The arbiter is back in IDLE next cycle.
- Read latency: the response passes to the owner in the same cycle as `mem_rsp.valid`. Minimum request-to-rsp is 1 cycle (N+1).
- Throughput: at most one outstanding transaction. Back-to-back grant every 2 cycles at best.
- Simultaneous new request and completion: the new request is evaluated only once IDLE is reached.
- `mem_req` holds stable while in ISSUE.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_e` {IDLE, ISSUE, WAIT_RSP}
  - `arb_owner_e` {OWN_INST, OWN_DATA}
  - `txn_kind_e` {TXN_NULL, TXN_READ, TXN_WRITE}
  - Classification function
- Reuse the existing `memory_io_req`/`memory_io_rsp` types.
- Sub-module `mem_arb_grant`: holds the priority decision and `starve_cnt` register.
  - Inputs: both pendings, IDLE strobe.
  - Output: `grant_data`.

## Test plan
- Lone fetch read at addr 0x100, memory acks at N+1 and returns 0x00500093 two cycles later → `inst_rsp.data` = 0x00500093 with valid, `data_rsp.valid` = 0, `busy` falls next cycle.
- Data write 0xCAFEF00D to 0x2000 with `do_write` = 0xF, ack at N+1 → `mem_req` fields match, no rsp on either side, IDLE at N+2.
- Both requesters held continuously with `STARVE_LIMIT` = 2 → grant order D, D, I, D, D, I.
- Read with `TIMEOUT_CYCLES` = 4 and no `mem_rsp` → owner rsp valid with data 0 in the 4th cycle after entering ISSUE, `timeout_err` = 1 and sticky.
- `reset` asserted low while in WAIT_RSP, then a late `mem_rsp.valid` → all outputs 0 immediately, late response not routed.
- Null request (`do_read` = `do_write` = 0) → ack pulse, `mem_req.valid` stays 0, state remains IDLE.
